port_bus_master: RTL

PORT_BUS_MASTER -- requirements
Module: port_bus_master

---
 rtl/port_bus_master.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/port_bus_master.sv
// port_bus_master: sequences one port-bus access per command.
// Each access has four phases. First the address and data are held stable
// for SETUP_CYCLES cycles. Then wen or ren is driven for STROBE_CYCLES
// cycles. Then both strobes are low for one HOLD cycle. Read data is
// captured at the end of HOLD and offered on the rsp_* handshake.
// Optional build macro: PORT_BUS_MASTER_FIFO_EN adds a 4-entry command FIFO
// in front of the state machine.
module port_bus_master #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] address,
    output logic [7:0] value_out,
    output logic       wen,
    output logic       ren,
    input  logic [7:0] port_in,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RESP
    } state_t;

    // Phase counters count down to zero, so load with (cycles - 1).
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_q;
    logic [7:0] address_q;
    logic [7:0] value_q;
    logic [7:0] rsp_data_q;

    // Command presented to the state machine (FIFO head or the raw port).
    logic       head_valid;
    logic       head_we;
    logic [7:0] head_addr;
    logic [7:0] head_data;
    logic       take;

    assign take = (state_q == S_IDLE) && head_valid;

`ifdef PORT_BUS_MASTER_FIFO_EN
    logic [16:0] fifo_mem [4];
    logic [1:0]  wr_ptr_q;
    logic [1:0]  rd_ptr_q;
    logic [2:0]  count_q;
    logic        push;

    assign cmd_ready  = !rst && (count_q != 3'd4);
    assign push       = cmd_valid && cmd_ready;
    assign head_valid = (count_q != 3'd0);
    assign {head_we, head_addr, head_data} = fifo_mem[rd_ptr_q];

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_we, cmd_addr, cmd_data};
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (take) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + {2'b00, push} - {2'b00, take};
        end
    end
`else
    // Without a FIFO the command is taken straight from the port while idle.
    assign cmd_ready  = !rst && (state_q == S_IDLE);
    assign head_valid = cmd_valid;
    assign head_we    = cmd_we;
    assign head_addr  = cmd_addr;
    assign head_data  = cmd_data;
`endif

    // Next-state logic: phase sequencing with down-counters for SETUP/STROBE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LOAD;
                end
            end
            S_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                state_d = we_q ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, command latch and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            address_q  <= 8'd0;
            value_q    <= 8'd0;
            rsp_data_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                we_q      <= head_we;
                address_q <= head_addr;
                // Reads leave the last written value on the bus.
                if (head_we) begin
                    value_q <= head_data;
                end
            end
            if ((state_q == S_HOLD) && !we_q) begin
                rsp_data_q <= port_in;
            end
        end
    end

    assign address   = address_q;
    assign value_out = value_q;
    assign rsp_data  = rsp_data_q;
    assign wen       = (state_q == S_STROBE) && we_q;
    assign ren       = (state_q == S_STROBE) && !we_q;
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);

endmodule
